// File: rtl/log2_arbiter.sv
// log2_arbiter: shares one combinational floor-log2 (MSB index) unit among
// N_REQ requesters. Each requester offers an operand with valid/ready; the
// winner is captured, evaluated one cycle later, and the result (degree,
// requester id, zero flag) is held on a registered response channel until
// the consumer takes it.
//
// Build option: define LOG2_ARB_RR_EN for round-robin arbitration with a
// rotating priority pointer. Without it the lowest valid index always wins
// and no pointer register exists. The port list is the same in both builds.
//
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high. A requester holds req_valid and
// req_num stable until that edge. rsp_* stay stable while rsp_valid is high
// and rsp_ready is low. req_ready depends on req_valid only and never on
// rsp_ready.
module log2_arbiter #(
  parameter int SIZE_IN  = 8,
  parameter int SIZE_OUT = $clog2(SIZE_IN),
  parameter int N_REQ    = 4,
  parameter int ID_W     = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*SIZE_IN-1:0] req_num,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [SIZE_OUT-1:0]      rsp_degree,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_zero
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [SIZE_IN-1:0]  op_q, op_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [SIZE_OUT-1:0] rsp_degree_q, rsp_degree_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic                rsp_zero_q, rsp_zero_d;

  // Arbiter results
  logic                any_valid;
  logic [ID_W-1:0]     grant_id;
  logic [N_REQ-1:0]    grant_oh;
  logic [SIZE_IN-1:0]  grant_num;
  logic                accept;

  // Shared log2 unit outputs
  logic [SIZE_OUT-1:0] log2_deg;
  logic                log2_zero;

`ifdef LOG2_ARB_RR_EN
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     rr_idx [N_REQ];

  // Candidate index for each search offset, starting at the pointer
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      rr_idx[i] = ID_W'((int'(ptr_q) + i) % N_REQ);
    end
  end

  // Round-robin pick: first valid index at or after the pointer, wrapping.
  // Iterating from the far end lets the nearest offset overwrite the rest.
  always_comb begin
    grant_id  = '0;
    any_valid = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[rr_idx[i]]) begin
        grant_id  = rr_idx[i];
        any_valid = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner on every accept
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      if (grant_id == ID_W'(N_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_id + 1'b1;
      end
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority pick: lowest valid index wins
  always_comb begin
    grant_id  = '0;
    any_valid = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_id  = ID_W'(i);
        any_valid = 1'b1;
      end
    end
  end
`endif

  // One-hot grant, ready only in IDLE and never while reset is asserted
  always_comb begin
    grant_oh = '0;
    if (any_valid) begin
      grant_oh = N_REQ'(1) << grant_id;
    end
    req_ready = '0;
    if (rst_n && (state_q == ST_IDLE)) begin
      req_ready = grant_oh;
    end
    accept = |(req_valid & req_ready);
  end

  // Operand mux for the granted requester
  always_comb begin
    grant_num = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        grant_num = req_num[i*SIZE_IN +: SIZE_IN];
      end
    end
  end

  // Shared log2: index of the highest set bit of op_q, 0 for op_q of 0 or 1
  always_comb begin
    log2_deg = '0;
    for (int i = 1; i < SIZE_IN; i++) begin
      if (op_q[i]) begin
        log2_deg = SIZE_OUT'(i);
      end
    end
    log2_zero = (op_q == '0);
  end

  // FSM next state and datapath register updates
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_degree_d = rsp_degree_q;
    rsp_id_d     = rsp_id_q;
    rsp_zero_d   = rsp_zero_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = grant_num;
          id_d    = grant_id;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        rsp_degree_d = log2_deg;
        rsp_zero_d   = log2_zero;
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        // Payload keeps its last value after the handshake
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight operand
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_degree_q <= '0;
      rsp_id_q     <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_degree_q <= rsp_degree_d;
      rsp_id_q     <= rsp_id_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_degree = rsp_degree_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_zero   = rsp_zero_q;

endmodule
